// File: rtl/muldiv_seq_if.sv
// ---------------------------------------------------------------------------
// muldiv_seq_if : request/response bundle for the sequential RV32M unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            kill;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            busy;

  modport master (
    output in_valid, op, a, b, kill, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, op, a, b, kill, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq : iterative RV32M multiply/divide unit (shift-add, restoring div)
// Optional MULDIV_FAST_MUL_EN: single-cycle multiplies.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  muldiv_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic             neg_q;
  logic [XLEN-1:0]  hi;
  logic [XLEN-1:0]  lo;
  logic [XLEN-1:0]  opnd;
  logic [XLEN-1:0]  result_q;
  logic             zero_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             in_ready_q;

  logic            accept;
  logic            is_div;
  logic            sign_a;
  logic            sign_b;
  logic            neg_a;
  logic            neg_b;
  logic            neg_in;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            b_is_zero;
  logic            overflow;
  logic            special;
  logic [XLEN-1:0] special_res;
  logic            fast_hit;
  logic [XLEN-1:0] fast_res;
  logic [XLEN-1:0] early_res;

  assign accept = (state == IDLE) && in_ready_q && bus.in_valid && !bus.kill;
  assign is_div = bus.op[2];
  assign sign_a = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                  (bus.op == OP_DIV)  || (bus.op == OP_REM);
  assign sign_b = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
  assign neg_a  = sign_a && bus.a[XLEN-1];
  assign neg_b  = sign_b && bus.b[XLEN-1];
  assign mag_a  = neg_a ? -bus.a : bus.a;
  assign mag_b  = neg_b ? -bus.b : bus.b;
  // Remainder follows the dividend's sign; products and quotients the XOR.
  assign neg_in = (is_div && bus.op[1]) ? neg_a : (neg_a ^ neg_b);

  assign b_is_zero   = (bus.b == '0);
  assign overflow    = is_div && !bus.op[0] && (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.b);
  assign special     = is_div && (b_is_zero || overflow);
  assign special_res = b_is_zero ? (bus.op[1] ? bus.a : {XLEN{1'b1}})
                                 : (bus.op[1] ? {XLEN{1'b0}} : bus.a);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a;
  logic [2*XLEN-1:0] fast_b;
  logic [2*XLEN-1:0] fast_prod;

  // Exact sign extension keeps the low 2*XLEN product bits correct.
  assign fast_a    = {{XLEN{neg_a}}, bus.a};
  assign fast_b    = {{XLEN{neg_b}}, bus.b};
  assign fast_prod = fast_a * fast_b;
  assign fast_hit  = !is_div;
  assign fast_res  = (bus.op[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
  assign fast_hit  = 1'b0;
  assign fast_res  = {XLEN{1'b0}};
`endif

  assign early_res = special ? special_res : fast_res;

  // The accept edge performs the first iteration straight from the inputs.
  logic [XLEN-1:0] src_hi;
  logic [XLEN-1:0] src_lo;
  logic [XLEN-1:0] src_opnd;
  logic            src_div;
  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   shifted;
  logic            ge;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] step_hi;
  logic [XLEN-1:0] step_lo;

  assign src_hi   = accept ? {XLEN{1'b0}} : hi;
  assign src_lo   = accept ? (is_div ? mag_a : mag_b) : lo;
  assign src_opnd = accept ? (is_div ? mag_b : mag_a) : opnd;
  assign src_div  = accept ? is_div : op_q[2];

  assign add_sum  = {1'b0, src_hi} + {1'b0, {XLEN{src_lo[0]}} & src_opnd};
  assign shifted  = {src_hi, src_lo[XLEN-1]};
  assign ge       = (shifted >= {1'b0, src_opnd});
  assign rem_next = shifted[XLEN-1:0] - src_opnd;

  assign step_hi  = src_div ? (ge ? rem_next : shifted[XLEN-1:0]) : add_sum[XLEN:1];
  assign step_lo  = src_div ? {src_lo[XLEN-2:0], ge} : {add_sum[0], src_lo[XLEN-1:1]};

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   final_res;

  assign prod_fix  = neg_q ? -{hi, lo} : {hi, lo};
  assign quo_fix   = neg_q ? -lo : lo;
  assign rem_fix   = neg_q ? -hi : hi;
  assign final_res = op_q[2] ? (op_q[1] ? rem_fix : quo_fix)
                             : ((op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                                     : prod_fix[2*XLEN-1:XLEN]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      opnd        <= '0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q       <= bus.op;
            neg_q      <= neg_in;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b0;
            if (special || fast_hit) begin
              result_q    <= early_res;
              zero_q      <= (early_res == '0);
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else begin
              hi    <= step_hi;
              lo    <= step_lo;
              opnd  <= src_opnd;
              cnt   <= CNT_W'(XLEN);
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.kill) begin
            cnt        <= '0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
            state      <= IDLE;
          end else if (cnt <= CNT_W'(1)) begin
            result_q    <= final_res;
            zero_q      <= (final_res == '0);
            out_valid_q <= 1'b1;
            cnt         <= '0;
            state       <= DONE;
          end else begin
            hi  <= step_hi;
            lo  <= step_lo;
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.kill || bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
          cnt         <= '0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.busy      = busy_q;

endmodule

`default_nettype wire

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width (even, >=8).
REQ-002 SHALL have parameter CNT_W, default $clog2(XLEN)+1, iteration counter width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  unit can accept; high only in IDLE.
REQ-007 op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 a, b  input  XLEN  operands rs1, rs2.
REQ-009 kill  input  1  abort in-flight operation.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 result  output  XLEN  operation result.
REQ-013 zero  output  1  high when result == 0.
REQ-014 busy  output  1  high in CALC or DONE.

Function
REQ-015 States IDLE, CALC, DONE; accept = in_valid && in_ready in IDLE; op, a, b are latched on the accept edge.
REQ-016 IDLE->CALC on a normal accept; IDLE->DONE on a special-case accept (REQ-020, REQ-021); CALC->DONE when the counter reaches 0; DONE->IDLE when out_ready is high.
REQ-017 Iterative ops SHALL assert out_valid exactly XLEN+1 cycles after the accept edge: XLEN edges of shift-add or restoring-division steps, then one sign-fixup edge.
REQ-018 MUL returns the low XLEN bits of the product; MULH, MULHSU and MULHU return the high XLEN bits for signed*signed, signed*unsigned and unsigned*unsigned operands respectively.
REQ-019 DIV and REM SHALL use sign-magnitude: quotient truncates toward zero, remainder takes the sign of the dividend; DIVU and REMU are unsigned.
REQ-020 Divide by zero: DIV and DIVU return all-ones, REM and REMU return a; out_valid SHALL assert 1 cycle after accept.
REQ-021 Signed overflow (a = -2^(XLEN-1), b = -1): DIV returns a, REM returns 0; out_valid SHALL assert 1 cycle after accept.
REQ-022 result and zero SHALL hold stable while out_valid is high and out_ready is low.
REQ-023 A new request is accepted no earlier than the cycle after DONE->IDLE; in_ready SHALL stay low in DONE even when out_ready is high.
REQ-024 kill in CALC or DONE SHALL force IDLE on the next edge with out_valid low and the result discarded; kill in IDLE SHALL block that cycle's accept.
REQ-025 kill has priority over out_ready and over CALC->DONE in the same cycle.
REQ-026 The counter SHALL be CNT_W bits, load XLEN on accept and decrement once per CALC edge; it SHALL never wrap.
REQ-027 Operand changes after the accept edge SHALL have no effect on the result.

Reset
REQ-028 rst_n low at a rising edge SHALL force IDLE from any state, including mid-CALC.
REQ-029 Reset values: out_valid=0, busy=0, result=0, zero=1, counter=0, in_ready=1 from the first cycle after reset release.
REQ-030 A request presented during a reset cycle SHALL NOT be accepted.

Configuration
REQ-031 Macro MULDIV_FAST_MUL_EN: when defined, MUL/MULH/MULHSU/MULHU SHALL use a single-cycle 2*XLEN-bit product and assert out_valid 1 cycle after accept.
REQ-032 Without MULDIV_FAST_MUL_EN, multiplies SHALL use the iterative path with XLEN+1 latency; division latency is unchanged in both builds.

Verification (XLEN=32)
REQ-033 DIV a=-7, b=2, out_ready=1 -> result 0xFFFFFFFD, out_valid exactly 33 cycles after accept; REM with the same operands -> 0xFFFFFFFF.
REQ-034 DIVU a=0x1234, b=0 -> result 0xFFFFFFFF after 1 cycle; REM a=-2^31, b=-1 -> result 0, zero=1, after 1 cycle.
REQ-035 MULH a=0x80000000, b=0x80000000 -> 0x40000000; MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFE; latency 1 with MULDIV_FAST_MUL_EN, 33 without.
REQ-036 DIVU 100/7 with out_ready held low for 5 cycles after out_valid -> result 14 held stable, in_ready low; in_ready rises 1 cycle after out_ready goes high.
REQ-037 DIV started, then kill pulsed at cycle 10 -> IDLE next edge, out_valid never asserts; next request MULHSU a=-1, b=2 -> 0xFFFFFFFF.
REQ-038 rst_n low for 1 cycle mid-CALC at iteration 20 -> all outputs at reset values next cycle; a subsequent REMU 10/3 -> result 1.
